// File: rtl/lz77_decoder.sv
// rtl/lz77_decoder.sv - LZ77 decoder: codeword handshake, 32-entry search buffer, overlapped copy
module lz77_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_valid,
  output logic       code_ready,
  input  logic [4:0] offset,
  input  logic [4:0] match_len,
  input  logic [7:0] char_nxt,
  output logic       out_valid,
  output logic [7:0] char_out,
  output logic       encode,
  output logic       finish
);

  localparam logic [7:0] TERM_CHAR = 8'h24;

  typedef enum logic [1:0] {S_IDLE, S_COPY, S_LIT, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [4:0] rem_q, rem_d;
  logic [4:0] off_q, off_d;
  logic [7:0] lit_q, lit_d;
  logic [7:0] sbuf_q [32];
  logic       code_ready_q, out_valid_q, finish_q;
  logic [7:0] char_out_q;

  logic       take;
  logic       do_copy;
  logic       lit_phase;
  logic       emit;
  logic [7:0] emit_char;

  // Outputs are registered, so each edge decides what the following cycle emits
  // and shifts that char into the buffer on the same edge; the next copy read
  // therefore already sees it, which is what makes overlapping matches work.
  always_comb begin
    state_d   = S_IDLE;
    rem_d     = rem_q;
    off_d     = off_q;
    lit_d     = lit_q;
    do_copy   = 1'b0;
    lit_phase = 1'b0;
    emit      = 1'b0;
    emit_char = 8'h00;
    take      = code_ready_q && code_valid;

    if (take) begin
      off_d = offset;
      lit_d = char_nxt;
      if (match_len != 5'd0) begin
        do_copy = 1'b1;
        rem_d   = match_len - 5'd1;
      end else begin
        lit_phase = 1'b1;
      end
    end else if (state_q == S_COPY) begin
      if (rem_q != 5'd0) begin
        do_copy = 1'b1;
        rem_d   = rem_q - 5'd1;
      end else begin
        lit_phase = 1'b1;
      end
    end

    if (do_copy) begin
      state_d   = S_COPY;
      emit      = 1'b1;
      emit_char = sbuf_q[off_d];
    end else if (lit_phase) begin
      // A terminating literal never gets a cycle of its own: go straight to DONE.
      if (lit_d != TERM_CHAR) begin
        state_d   = S_LIT;
        emit      = 1'b1;
        emit_char = lit_d;
      end else begin
        state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rem_q        <= 5'd0;
      off_q        <= 5'd0;
      lit_q        <= 8'h00;
      code_ready_q <= 1'b0;
      out_valid_q  <= 1'b0;
      char_out_q   <= 8'h00;
      finish_q     <= 1'b0;
      for (int i = 0; i < 32; i++) sbuf_q[i] <= 8'h00;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      off_q        <= off_d;
      lit_q        <= lit_d;
      code_ready_q <= (state_d == S_IDLE) || (state_d == S_LIT);
      out_valid_q  <= emit;
      char_out_q   <= emit_char;
      finish_q     <= (state_d == S_DONE);
      if (state_d == S_DONE) begin
        for (int i = 0; i < 32; i++) sbuf_q[i] <= 8'h00;
      end else if (emit) begin
        sbuf_q[0] <= emit_char;
        for (int i = 1; i < 32; i++) sbuf_q[i] <= sbuf_q[i-1];
      end
    end
  end

  assign code_ready = code_ready_q;
  assign out_valid  = out_valid_q;
  assign char_out   = char_out_q;
  assign finish     = finish_q;
  assign encode     = 1'b0;

endmodule

// File: tb/tb_lz77_decoder.sv
// tb/tb_lz77_decoder.sv - directed self-checking bench for lz77_decoder
module tb_lz77_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       code_valid = 1'b0;
  logic       code_ready;
  logic [4:0] offset = 5'd0;
  logic [4:0] match_len = 5'd0;
  logic [7:0] char_nxt = 8'h00;
  logic       out_valid;
  logic [7:0] char_out;
  logic       encode;
  logic       finish;

  int errors = 0;
  int checks = 0;

  lz77_decoder dut (
    .clk(clk), .reset(reset), .code_valid(code_valid), .code_ready(code_ready),
    .offset(offset), .match_len(match_len), .char_nxt(char_nxt),
    .out_valid(out_valid), .char_out(char_out), .encode(encode), .finish(finish)
  );

  always #5 clk = ~clk;

  // Outputs are sampled on the falling edge throughout.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if ((finish && out_valid) !== 1'b0) begin
        errors++;
        $display("FAIL finish_and_valid: finish=%0b out_valid=%0b required not both 1", finish, out_valid);
      end
    end
  end

  task automatic do_reset;
    reset = 1'b1;
    code_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input logic [4:0] o, input logic [4:0] l, input logic [7:0] c);
    code_valid = 1'b1;
    offset = o;
    match_len = l;
    char_nxt = c;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (code_ready !== 1'b0) begin errors++; $display("FAIL reset_code_ready: got %0b want 0", code_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (char_out !== 8'h00) begin errors++; $display("FAIL reset_char_out: got %h want 00", char_out); end
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish: got %0b want 0", finish); end
    checks++; if (encode !== 1'b0) begin errors++; $display("FAIL reset_encode: got %0b want 0", encode); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (code_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %0b want 1", code_ready); end
  endtask

  task automatic test_literal;
    send(5'd0, 5'd0, 8'h03);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lit_valid: got %0b want 1", out_valid); end
    checks++; if (char_out !== 8'h03) begin errors++; $display("FAIL lit_char: got %h want 03", char_out); end
    checks++; if (code_ready !== 1'b1) begin errors++; $display("FAIL lit_ready: got %0b want 1", code_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lit_idle_valid: got %0b want 0", out_valid); end
    checks++; if (char_out !== 8'h00) begin errors++; $display("FAIL lit_idle_char: got %h want 00", char_out); end
  endtask

  task automatic test_overlap;
    logic [7:0] exp_c [8] = '{8'h01, 8'h02, 8'h01, 8'h02, 8'h01, 8'h02, 8'h01, 8'h07};
    logic       exp_r [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 8; k++) begin
      if (k == 0) send(5'd0, 5'd0, 8'h01);
      else if (k == 1) send(5'd0, 5'd0, 8'h02);
      else if (k == 2) send(5'd1, 5'd5, 8'h07);
      else @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL overlap_valid[%0d]: got %0b want 1", k, out_valid); end
      checks++; if (char_out !== exp_c[k]) begin errors++; $display("FAIL overlap_char[%0d]: got %h want %h", k, char_out, exp_c[k]); end
      checks++; if (code_ready !== exp_r[k]) begin errors++; $display("FAIL overlap_ready[%0d]: got %0b want %0b", k, code_ready, exp_r[k]); end
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL overlap_span_end: got %0b want 0", out_valid); end
  endtask

  task automatic test_termination;
    do_reset();
    send(5'd0, 5'd0, 8'h01);
    send(5'd0, 5'd0, 8'h02);
    send(5'd1, 5'd2, 8'h24);
    checks++; if (char_out !== 8'h01 || out_valid !== 1'b1) begin errors++; $display("FAIL term_c0: got %h/%0b want 01/1", char_out, out_valid); end
    checks++; if (code_ready !== 1'b0) begin errors++; $display("FAIL term_ready_c0: got %0b want 0", code_ready); end
    @(negedge clk);
    checks++; if (char_out !== 8'h02 || out_valid !== 1'b1) begin errors++; $display("FAIL term_c1: got %h/%0b want 02/1", char_out, out_valid); end
    @(negedge clk);
    checks++; if (finish !== 1'b1) begin errors++; $display("FAIL term_finish: got %0b want 1", finish); end
    checks++; if (out_valid !== 1'b0 || char_out !== 8'h00) begin errors++; $display("FAIL term_end_out: got %0b/%h want 0/00", out_valid, char_out); end
    checks++; if (code_ready !== 1'b0) begin errors++; $display("FAIL term_end_ready: got %0b want 0", code_ready); end
    @(negedge clk);
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL term_finish_pulse: got %0b want 0", finish); end
    checks++; if (code_ready !== 1'b1) begin errors++; $display("FAIL term_ready_after: got %0b want 1", code_ready); end
    send(5'd3, 5'd1, 8'h05);
    checks++; if (char_out !== 8'h00 || out_valid !== 1'b1) begin errors++; $display("FAIL term_cleared_buf: got %h/%0b want 00/1", char_out, out_valid); end
    @(negedge clk);
    checks++; if (char_out !== 8'h05) begin errors++; $display("FAIL term_next_lit: got %h want 05", char_out); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 10; k++) begin
      send(5'd0, 5'd0, 8'(k));
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %0b want 1", k, out_valid); end
      checks++; if (char_out !== 8'(k)) begin errors++; $display("FAIL b2b_char[%0d]: got %h want %h", k, char_out, 8'(k)); end
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail: got %0b want 0", out_valid); end
  endtask

  task automatic test_max_len;
    logic [7:0] want;
    send(5'd0, 5'd0, 8'h0A);
    send(5'd0, 5'd31, 8'h0B);
    for (int i = 1; i <= 32; i++) begin
      if (i > 1) @(negedge clk);
      want = (i <= 31) ? 8'h0A : 8'h0B;
      checks++; if (out_valid !== 1'b1 || char_out !== want) begin errors++; $display("FAIL maxlen_char[%0d]: got %h/%0b want %h/1", i, char_out, out_valid, want); end
      checks++; if (code_ready !== (i == 32)) begin errors++; $display("FAIL maxlen_ready[%0d]: got %0b want %0b", i, code_ready, (i == 32)); end
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL maxlen_tail: got %0b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_copy;
    send(5'd0, 5'd0, 8'h33);
    send(5'd0, 5'd10, 8'h44);
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b1 || char_out !== 8'h33) begin errors++; $display("FAIL midcopy_c3: got %h/%0b want 33/1", char_out, out_valid); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || char_out !== 8'h00) begin errors++; $display("FAIL midcopy_rst_out: got %0b/%h want 0/00", out_valid, char_out); end
    checks++; if (code_ready !== 1'b0 || finish !== 1'b0) begin errors++; $display("FAIL midcopy_rst_ctl: got %0b/%0b want 0/0", code_ready, finish); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (code_ready !== 1'b1 || finish !== 1'b0) begin errors++; $display("FAIL midcopy_ready: got %0b/%0b want 1/0", code_ready, finish); end
    send(5'd5, 5'd0, 8'h04);
    checks++; if (out_valid !== 1'b1 || char_out !== 8'h04) begin errors++; $display("FAIL midcopy_next: got %h/%0b want 04/1", char_out, out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || finish !== 1'b0) begin errors++; $display("FAIL midcopy_tail: got %0b/%0b want 0/0", out_valid, finish); end
    checks++; if (encode !== 1'b0) begin errors++; $display("FAIL encode_tied: got %0b want 0", encode); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_literal();
    test_overlap();
    test_termination();
    test_back_to_back();
    test_max_len();
    test_reset_mid_copy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lz77_decoder.md
LZ77_DECODER -- requirements
Module: lz77_decoder

Interface
REQ-001 SHALL expose the following ports, clock and reset first:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- code_valid  in  1  codeword present on offset/match_len/char_nxt.
- code_ready  out  1  block accepts the codeword this cycle.
- offset  in  5  search-buffer index of the first matched char, 0 = most recent.
- match_len  in  5  number of chars copied from the buffer, 0..31.
- char_nxt  in  8  literal following the match; 8'h24 ('$') terminates the string.
- out_valid  out  1  char_out holds a decoded char this cycle.
- char_out  out  8  decoded char.
- encode  out  1  mode flag, tied 0 (decoder).
- finish  out  1  one-cycle pulse at end of string.

REQ-002 SHALL accept a codeword only on a cycle where code_valid=1 and code_ready=1 (the handshake); offset/match_len/char_nxt SHALL be captured internally on that edge and ignored at all other times.

Function
REQ-003 SHALL hold a 32-entry x 8-bit search buffer; entry 0 is the most recently emitted char; every emitted char shifts the buffer by one (entry 31 discarded).
REQ-004 SHALL implement the FSM IDLE -> COPY -> LIT -> (IDLE | END):
- IDLE: code_ready=1; on handshake go to COPY if match_len>0, else LIT.
- COPY: emit buffer[offset] (sampled before that cycle's shift), decrement remaining; after match_len emits go to LIT.
- LIT: if literal != 8'h24, emit literal; else go to END without emitting.
- END: finish=1 for exactly one cycle, clear buffer to 8'h00, return to IDLE.
REQ-005 Copy source index SHALL stay equal to offset for every COPY cycle, so overlapping matches (match_len > offset+1) replicate correctly.
REQ-006 First decoded char SHALL appear (out_valid=1) the cycle after the handshake; a codeword SHALL occupy exactly match_len+1 cycles (match_len for a terminating codeword, plus one END cycle).
REQ-007 code_ready SHALL also be 1 during a non-terminating LIT cycle; a handshake there SHALL proceed directly to COPY/LIT with no idle bubble, giving back-to-back throughput of one char per cycle.
REQ-008 code_ready SHALL be 0 in COPY, END and terminating LIT.
REQ-009 out_valid=1 only in COPY and non-terminating LIT cycles; char_out SHALL be 8'h00 when out_valid=0.
REQ-010 offset referencing entries not yet written SHALL return the buffer contents (8'h00 after reset/END); no error flag.
REQ-011 match_len counter SHALL be 5 bits; match_len=31 SHALL emit 31 copy chars plus the literal (32 cycles).
REQ-012 encode SHALL be 0 at all times.
REQ-013 finish and out_valid SHALL never be 1 in the same cycle.

Reset
REQ-014 While reset=1 at a rising edge: state=IDLE, buffer all 8'h00, counters 0; outputs code_ready=0, out_valid=0, char_out=8'h00, finish=0, encode=0.
REQ-015 First cycle after reset deasserts: code_ready=1.
REQ-016 Reset asserted mid-COPY/LIT/END SHALL take priority over all other activity; the pending codeword is discarded and no finish pulse is emitted.

Verification
REQ-017 Literal only: code (0,0,8'h03) -> next cycle out_valid=1, char_out=8'h03; code_ready=1 same cycle.
REQ-018 Overlap copy: codes (0,0,1),(0,0,2),(1,5,7) -> char_out stream 1,2,1,2,1,2,1,7; codeword 3 spans 6 cycles.
REQ-019 Termination: after stream 1,2 send (1,2,8'h24) -> outputs 1,2 then finish=1 one cycle with out_valid=0, then code_ready=1 and buffer reads 8'h00.
REQ-020 Back-to-back: code_valid held 1 with ten (0,0,k) codewords k=0..9 -> ten consecutive out_valid cycles, no gaps.
REQ-021 Max length: after literal 8'h0A send (0,31,8'h0B) -> 31 chars of 8'h0A then 8'h0B, 32 cycles, code_ready=0 for first 31.
REQ-022 Reset mid-copy: assert reset during cycle 3 of a match_len=10 copy -> next cycle all outputs at reset values; next codeword (5,0,8'h04) emits 8'h04 only.
